// File: rtl/oci_trace_pkg.sv
// Shared types and helpers for the OCI trace capture buffer.
// State encoding and width helpers used by the top and the store.
package oci_trace_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam int DATA_W_DEF  = 30;
  localparam int COUNT_W_DEF = 4;
  localparam int ENTRY_W_DEF = DATA_W_DEF + COUNT_W_DEF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int entry_w(input int dw, input int cw);
    return dw + cw;
  endfunction

endpackage

// File: rtl/oci_trace_ram.sv
// Trace entry store: DEPTH x WIDTH simple dual-port memory.
// Synchronous write, asynchronous read of the oldest entry.
module oci_trace_ram
  import oci_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = ENTRY_W_DEF,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Registered write port; no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/oci_trace_capture.sv
// OCI trace capture: circular store, trigger countdown, freeze, drain.
// Control FSM, pointers and counters; storage lives in oci_trace_ram.
module oci_trace_capture
  import oci_trace_pkg::*;
#(
  parameter int DATA_W    = 30,
  parameter int COUNT_W   = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int DROP_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         trc_valid,
  input  logic [DATA_W-1:0]            trc_data,
  input  logic [COUNT_W-1:0]           trc_count,
  input  logic                         mode_wrap,
  input  logic                         test_ending,
  input  logic                         rearm,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_W+COUNT_W-1:0]    rd_data,
  output logic                         rd_last,
  output logic                         capture_done,
  output logic [clog2(DEPTH):0]        fill_level,
  output logic                         wrapped,
  output logic [DROP_W-1:0]            dropped_count
);

  localparam int ENTRY_W = entry_w(DATA_W, COUNT_W);
  localparam int PTR_W   = clog2(DEPTH);
  localparam int FILL_W  = PTR_W + 1;

  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] POST_LVL = FILL_W'(POST_TRIG);
  localparam logic [FILL_W-1:0] ONE      = FILL_W'(1);
  localparam logic [PTR_W-1:0]  PSTEP    = PTR_W'(1);

  state_t state_q, state_d;
  logic [FILL_W-1:0] post_q, post_d;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill_q;
  logic              wrapped_q;
  logic [DROP_W-1:0] drop_q;

  logic live, qual, full, frozen;
  logic write_new, overwrite, drop, pop;
  logic [ENTRY_W-1:0] ram_rdata;

  assign live   = !reset && !rearm;
  assign frozen = (state_q == FROZEN);
  assign full   = (fill_q == FULL_LVL);
  assign qual   = live && trc_valid
                  && (trc_count != '0)
                  && (state_q == ARMED
                      || state_q == POST);

  assign write_new = qual && !full;
  assign overwrite = qual && full && mode_wrap;
  assign drop      = qual && full && !mode_wrap;
  assign pop       = live && frozen
                     && (fill_q != '0) && rd_ready;

  // State and post-trigger countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARMED;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  // Next-state: trigger, countdown to freeze, rearm override.
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    unique case (state_q)
      ARMED: begin
        if (test_ending) begin
          if (POST_TRIG == 0) begin
            state_d = FROZEN;
          end else begin
            state_d = POST;
            post_d  = POST_LVL;
          end
        end
      end
      POST: begin
        if (qual) begin
          post_d = post_q - ONE;
          if (post_q == ONE) state_d = FROZEN;
        end
      end
      FROZEN: begin
      end
      default: state_d = ARMED;
    endcase
    if (rearm) begin
      state_d = ARMED;
      post_d  = '0;
    end
  end

  // Pointers, fill level and sticky status counters.
  always_ff @(posedge clk) begin
    if (reset || rearm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_q    <= '0;
      wrapped_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      unique case (1'b1)
        write_new: begin
          wr_ptr <= wr_ptr + PSTEP;
          fill_q <= fill_q + ONE;
        end
        overwrite: begin
          wr_ptr    <= wr_ptr + PSTEP;
          rd_ptr    <= rd_ptr + PSTEP;
          wrapped_q <= 1'b1;
        end
        drop: begin
          if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
        pop: begin
          rd_ptr <= rd_ptr + PSTEP;
          fill_q <= fill_q - ONE;
        end
        default: begin
        end
      endcase
    end
  end

  oci_trace_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (write_new || overwrite),
    .waddr (wr_ptr),
    .wdata ({trc_count, trc_data}),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rd_valid      = frozen && (fill_q != '0);
  assign rd_data       = ram_rdata;
  assign rd_last       = rd_valid && (fill_q == ONE);
  assign capture_done  = frozen;
  assign fill_level    = fill_q;
  assign wrapped       = wrapped_q;
  assign dropped_count = drop_q;

endmodule

// File: tb/tb_oci_trace_capture.sv
// Directed bench for oci_trace_capture.
// Instance a: DEPTH=8 POST_TRIG=3; instance b: DEPTH=8 POST_TRIG=0.
module tb_oci_trace_capture;

  logic clk = 1'b0;
  logic reset;

  logic        trc_valid, mode_wrap, test_ending, rearm, rd_ready;
  logic [29:0] trc_data;
  logic [3:0]  trc_count;
  logic        rd_valid, rd_last, capture_done, wrapped;
  logic [33:0] rd_data;
  logic [3:0]  fill_level;
  logic [15:0] dropped_count;

  logic        b_valid, b_wrap, b_te, b_rearm, b_ready;
  logic [29:0] b_data;
  logic [3:0]  b_count;
  logic        b_rd_valid, b_rd_last, b_done, b_wrapped;
  logic [33:0] b_rd_data;
  logic [3:0]  b_fill;
  logic [15:0] b_dropped;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oci_trace_capture #(
    .DATA_W(30), .COUNT_W(4), .DEPTH(8),
    .POST_TRIG(3), .DROP_W(16)
  ) dut_a (
    .clk(clk), .reset(reset),
    .trc_valid(trc_valid), .trc_data(trc_data),
    .trc_count(trc_count), .mode_wrap(mode_wrap),
    .test_ending(test_ending), .rearm(rearm),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .capture_done(capture_done),
    .fill_level(fill_level), .wrapped(wrapped),
    .dropped_count(dropped_count)
  );

  oci_trace_capture #(
    .DATA_W(30), .COUNT_W(4), .DEPTH(8),
    .POST_TRIG(0), .DROP_W(16)
  ) dut_b (
    .clk(clk), .reset(reset),
    .trc_valid(b_valid), .trc_data(b_data),
    .trc_count(b_count), .mode_wrap(b_wrap),
    .test_ending(b_te), .rearm(b_rearm),
    .rd_valid(b_rd_valid), .rd_ready(b_ready),
    .rd_data(b_rd_data), .rd_last(b_rd_last),
    .capture_done(b_done),
    .fill_level(b_fill), .wrapped(b_wrapped),
    .dropped_count(b_dropped)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [29:0] d,
                      input logic [3:0] c,
                      input logic te);
    trc_valid = 1'b1;
    trc_data = d;
    trc_count = c;
    test_ending = te;
    tick();
    trc_valid = 1'b0;
    trc_count = '0;
    test_ending = 1'b0;
  endtask

  task automatic pop(input string tag,
                     input logic [29:0] d,
                     input logic last);
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, "_data"}, 64'(rd_data), 64'({4'd1, d}));
    chk({tag, "_last"}, 64'(rd_last), 64'(last));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic push_b(input logic [29:0] d,
                        input logic te);
    b_valid = 1'b1;
    b_data = d;
    b_count = 4'd1;
    b_te = te;
    tick();
    b_valid = 1'b0;
    b_count = '0;
    b_te = 1'b0;
  endtask

  task automatic pop_b(input string tag,
                       input logic [29:0] d,
                       input logic last);
    chk({tag, "_valid"}, 64'(b_rd_valid), 64'd1);
    chk({tag, "_data"}, 64'(b_rd_data), 64'({4'd1, d}));
    chk({tag, "_last"}, 64'(b_rd_last), 64'(last));
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    trc_valid = 0; trc_data = '0; trc_count = '0;
    mode_wrap = 0; test_ending = 0; rearm = 0;
    rd_ready = 0;
    b_valid = 0; b_data = '0; b_count = '0;
    b_wrap = 0; b_te = 0; b_rearm = 0; b_ready = 0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_done", 64'(capture_done), 64'd0);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    chk("rst_wrap", 64'(wrapped), 64'd0);
    chk("rst_drop", 64'(dropped_count), 64'd0);
    chk("rst_b_done", 64'(b_done), 64'd0);

    // stop mode: overflow drops newest
    mode_wrap = 1'b0;
    for (int i = 1; i <= 10; i++) push(30'(i), 4'd1, 1'b0);
    chk("t1_fill", 64'(fill_level), 64'd8);
    chk("t1_drop", 64'(dropped_count), 64'd2);
    chk("t1_rdv_armed", 64'(rd_valid), 64'd0);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    chk("t1_done_trig", 64'(capture_done), 64'd0);
    push(30'd11, 4'd1, 1'b0);
    push(30'd12, 4'd1, 1'b0);
    chk("t1_done_early", 64'(capture_done), 64'd0);
    push(30'd13, 4'd1, 1'b0);
    chk("t1_done", 64'(capture_done), 64'd1);
    chk("t1_drop5", 64'(dropped_count), 64'd5);
    for (int i = 1; i <= 8; i++) pop("t1_pop", 30'(i), i == 8);
    chk("t1_empty_rdv", 64'(rd_valid), 64'd0);
    chk("t1_empty_fill", 64'(fill_level), 64'd0);
    chk("t1_still_done", 64'(capture_done), 64'd1);

    // wrap mode: newest eight kept
    do_rearm();
    chk("t2_rearm_drop", 64'(dropped_count), 64'd0);
    chk("t2_rearm_done", 64'(capture_done), 64'd0);
    mode_wrap = 1'b1;
    for (int i = 1; i <= 11; i++) push(30'(i), 4'd1, 1'b0);
    push(30'd12, 4'd1, 1'b1);
    chk("t2_done_trig", 64'(capture_done), 64'd0);
    for (int i = 13; i <= 15; i++) push(30'(i), 4'd1, 1'b0);
    chk("t2_wrapped", 64'(wrapped), 64'd1);
    chk("t2_done", 64'(capture_done), 64'd1);
    chk("t2_fill", 64'(fill_level), 64'd8);
    for (int i = 8; i <= 15; i++) pop("t2_pop", 30'(i), i == 15);

    // POST_TRIG=0: trigger entry is the last one kept
    push_b(30'h11, 1'b0);
    push_b(30'h22, 1'b0);
    chk("t3_done_pre", 64'(b_done), 64'd0);
    push_b(30'hAA, 1'b1);
    chk("t3_done", 64'(b_done), 64'd1);
    push_b(30'hBB, 1'b0);
    chk("t3_fill", 64'(b_fill), 64'd3);
    pop_b("t3_pop0", 30'h11, 1'b0);
    pop_b("t3_pop1", 30'h22, 1'b0);
    pop_b("t3_pop2", 30'hAA, 1'b1);
    chk("t3_empty", 64'(b_rd_valid), 64'd0);

    // zero-count entries ignored during POST
    do_rearm();
    chk("t4_rearm_wrap", 64'(wrapped), 64'd0);
    mode_wrap = 1'b0;
    push(30'd1, 4'd1, 1'b0);
    push(30'd2, 4'd1, 1'b0);
    push(30'd3, 4'd1, 1'b1);
    push(30'h50, 4'd0, 1'b0);
    chk("t4_fill_zc", 64'(fill_level), 64'd3);
    push(30'd4, 4'd1, 1'b0);
    push(30'h51, 4'd0, 1'b0);
    push(30'd5, 4'd1, 1'b0);
    chk("t4_done_2", 64'(capture_done), 64'd0);
    push(30'h52, 4'd0, 1'b0);
    chk("t4_done_zc", 64'(capture_done), 64'd0);
    chk("t4_fill_5", 64'(fill_level), 64'd5);
    push(30'd6, 4'd1, 1'b0);
    chk("t4_done", 64'(capture_done), 64'd1);
    chk("t4_fill_6", 64'(fill_level), 64'd6);

    // drain with rd_ready 1,0,0,1
    chk("t5_d1", 64'(rd_data), 64'({4'd1, 30'd1}));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t5_fill_a", 64'(fill_level), 64'd5);
    chk("t5_d2", 64'(rd_data), 64'({4'd1, 30'd2}));
    tick();
    chk("t5_stall1_d", 64'(rd_data), 64'({4'd1, 30'd2}));
    chk("t5_stall1_v", 64'(rd_valid), 64'd1);
    tick();
    chk("t5_stall2_d", 64'(rd_data), 64'({4'd1, 30'd2}));
    chk("t5_stall2_f", 64'(fill_level), 64'd5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t5_fill_b", 64'(fill_level), 64'd4);
    for (int i = 3; i <= 6; i++) pop("t5_pop", 30'(i), i == 6);

    // rearm mid-POST with a simultaneous write
    do_rearm();
    push(30'd1, 4'd1, 1'b0);
    push(30'd2, 4'd1, 1'b1);
    trc_valid = 1'b1;
    trc_data = 30'd9;
    trc_count = 4'd1;
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    trc_valid = 1'b0;
    trc_count = '0;
    chk("t6_fill", 64'(fill_level), 64'd0);
    chk("t6_done", 64'(capture_done), 64'd0);
    chk("t6_rdv", 64'(rd_valid), 64'd0);
    push(30'd7, 4'd1, 1'b1);
    chk("t6_armed_wr", 64'(fill_level), 64'd1);
    for (int i = 8; i <= 10; i++) push(30'(i), 4'd1, 1'b0);
    chk("t6_frozen", 64'(capture_done), 64'd1);
    pop("t6_pop", 30'd7, 1'b0);

    // reset mid-drain
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_fill", 64'(fill_level), 64'd0);
    chk("t6_rst_done", 64'(capture_done), 64'd0);
    chk("t6_rst_rdv", 64'(rd_valid), 64'd0);
    chk("t6_rst_wrap", 64'(wrapped), 64'd0);
    chk("t6_rst_drop", 64'(dropped_count), 64'd0);
    chk("t6_rst_b_done", 64'(b_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oci_trace_capture.md
Name: oci_trace_capture

Overview:
Parametrised debug-trace capture buffer for the CPU on-chip-instrumentation path. It records {dct_count, dct_buffer}-style trace entries into a circular store and, after a trigger (test_ending), captures a programmable number of post-trigger entries. It then freezes and lets a host drain the store oldest-first over a valid/ready port. It sits between the OCI trace source and the debug/JTAG readout logic.

Parameters:
DATA_W, 30, trace data word width
COUNT_W, 4, width of per-entry count/tag field
DEPTH, 16, entries in store; power of two, >= 2
POST_TRIG, 4, entries captured after trigger before freeze; 0..DEPTH
DROP_W, 16, width of saturating dropped-entry counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
trc_valid  in  1  trace entry present this cycle
trc_data  in  DATA_W  trace data word
trc_count  in  COUNT_W  valid-unit count for entry; 0 = empty entry
mode_wrap  in  1  1 = overwrite oldest when full, 0 = drop newest when full
test_ending  in  1  trigger pulse
rearm  in  1  clear store and restart capture
rd_valid  out  1  read entry available
rd_ready  in  1  consumer accepts entry
rd_data  out  DATA_W+COUNT_W  {count, data} of oldest entry
rd_last  out  1  rd_valid entry is the final one
capture_done  out  1  store frozen
fill_level  out  clog2(DEPTH)+1  entries held
wrapped  out  1  at least one entry overwritten since arm
dropped_count  out  DROP_W  entries dropped (stop mode), saturating

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). Both reset and rearm force: state ARMED, pointers 0, fill_level 0, wrapped 0, dropped_count 0, capture_done 0, rd_valid 0.
- rearm takes priority over trigger, write and read in the same cycle. Any write or read in that cycle is discarded.
- Write qualifier: trc_valid && trc_count != 0 && state in {ARMED, POST}. Entries with count 0 are ignored and do not affect the post-trigger countdown.
- When not full, a qualified write stores the entry at wr_ptr, increments wr_ptr (mod DEPTH) and increments fill.
- When full with mode_wrap=1: the new entry overwrites the oldest, both pointers advance, fill stays DEPTH, and wrapped is set.
- When full with mode_wrap=0: the entry is dropped and dropped_count increments, saturating at all-ones.
- States:
  - ARMED: on test_ending, go to POST with post_cnt=POST_TRIG, or to FROZEN if POST_TRIG=0. The entry written in the trigger cycle is captured and is not counted as post-trigger.
  - POST: each qualified entry decrements post_cnt, whether stored, overwritten or dropped. When the decrement reaches 0, go to FROZEN next cycle. test_ending is ignored.
  - FROZEN: capture_done=1, no writes, test_ending ignored. The state persists until rearm or reset, including after the store is fully drained.
- Read port (FROZEN only):
  - rd_valid = (fill != 0).
  - rd_data shows the entry at rd_ptr combinationally from registered storage.
  - rd_last = rd_valid && fill == 1.
  - rd_valid && rd_ready pops: rd_ptr advances, fill decrements, on the same edge.
  - rd_data and rd_valid stay stable while rd_ready=0.
  - rd_ready is ignored when rd_valid=0.
- Latency: write visible in fill_level the cycle after the edge. Trigger-to-capture_done is 1 cycle when POST_TRIG=0, else 1 cycle after the final post-trigger entry edge.
- fill_level never exceeds DEPTH. Pointers wrap at DEPTH with no special case.

Decomposition:
- Shared package/include oci_trace_pkg:
  - state encoding ARMED/POST/FROZEN
  - ENTRY_W = DATA_W+COUNT_W
  - ptr-width function clog2
- One sub-module, oci_trace_ram:
  - simple dual-port DEPTH x ENTRY_W
  - synchronous write, asynchronous read
- Control FSM, pointers and counters live in the top module.

Test Plan:
1. DEPTH=8, POST_TRIG=3, mode_wrap=0: write data 1..10 (count=1) -> fill_level=8, dropped_count=2. Pulse test_ending, write 3 more -> capture_done=1, dropped_count=5. Drain yields 1..8, rd_last on 8.
2. mode_wrap=1, same sizes: write 1..12 with test_ending coincident with 12, then 13..15 -> wrapped=1, capture_done=1. Drain yields 8..15.
3. POST_TRIG=0 instance: trigger cycle carries entry 0xAA -> capture_done=1 next cycle. 0xAA is the last drained entry; a further trc_valid is ignored.
4. trc_count=0 entries interleaved during POST -> fill_level and countdown unchanged. Freeze occurs only after 3 non-zero-count entries.
5. Drain with rd_ready toggling 1,0,0,1 -> no entry skipped or duplicated, rd_data stable during stalls, fill_level decrements only on handshake.
6. rearm asserted mid-POST with simultaneous trc_valid, and reset asserted mid-drain -> next cycle state ARMED, fill_level=0, capture_done=0, rd_valid=0, wrapped=0, dropped_count=0.
